// File: rtl/systolic_output_buffer.sv
// Output deskew for the systolic array: column j is delayed (length-j) stages so a
// row leaves as one aligned vector, with a valid flag and a tile-last marker.
module systolic_output_buffer #(
  parameter int ACC_WIDTH = 32,
  parameter int length    = 16,
  parameter int ROWS      = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [ACC_WIDTH*length-1:0]   din,
  input  logic                          din_valid,
  output logic [ACC_WIDTH*length-1:0]   dout,
  output logic                          dout_valid,
  output logic                          dout_last
);

  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             w_validIn;
  logic             r_doutValid;
  logic             r_doutLast;
  logic [CNT_W-1:0] r_rowCnt;

  // w_validIn is the valid bit about to enter the output stage.
  generate
    if (length == 1) begin : g_validDirect
      assign w_validIn = din_valid;
    end else begin : g_validPipe
      logic [length-2:0] r_validPipe;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_validPipe <= '0;
        end else begin
          r_validPipe[0] <= din_valid;
          for (int k = 1; k < length - 1; k++) begin
            r_validPipe[k] <= r_validPipe[k-1];
          end
        end
      end

      assign w_validIn = r_validPipe[length-2];
    end
  endgenerate

  // Each column: (length-j-1) plain delay stages, then a masked output register.
  generate
    for (genvar j = 0; j < length; j++) begin : g_col
      localparam int DEPTH = length - j;
      logic [ACC_WIDTH-1:0] w_colIn;
      logic [ACC_WIDTH-1:0] r_outCol;

      if (DEPTH == 1) begin : g_direct
        assign w_colIn = din[ACC_WIDTH*j +: ACC_WIDTH];
      end else begin : g_chain
        logic [ACC_WIDTH-1:0] r_chain [DEPTH-1];

        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
              r_chain[k] <= '0;
            end
          end else begin
            r_chain[0] <= din[ACC_WIDTH*j +: ACC_WIDTH];
            for (int k = 1; k < DEPTH - 1; k++) begin
              r_chain[k] <= r_chain[k-1];
            end
          end
        end

        assign w_colIn = r_chain[DEPTH-2];
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_outCol <= '0;
        end else begin
          r_outCol <= w_validIn ? w_colIn : '0;
        end
      end

      assign dout[ACC_WIDTH*j +: ACC_WIDTH] = r_outCol;
    end
  endgenerate

  // Row counter advances with each beat loaded into the output stage; it holds across gaps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_doutValid <= 1'b0;
      r_doutLast  <= 1'b0;
      r_rowCnt    <= '0;
    end else begin
      r_doutValid <= w_validIn;
      r_doutLast  <= w_validIn && (r_rowCnt == LAST_ROW);
      if (w_validIn) begin
        r_rowCnt <= (r_rowCnt == LAST_ROW) ? '0 : r_rowCnt + CNT_ONE;
      end
    end
  end

  assign dout_valid = r_doutValid;
  assign dout_last  = r_doutLast;

endmodule

// File: tb/tb_systolic_output_buffer.sv
// Directed table-driven bench for systolic_output_buffer (length=4, ROWS=3) plus a
// hand-written sequence for the degenerate length=1, ROWS=1 configuration.
module tb_systolic_output_buffer;

  localparam int W = 32;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic [W*L-1:0] din;
  logic           dinValid;
  logic [W*L-1:0] dout;
  logic           doutValid;
  logic           doutLast;

  logic [W-1:0]   din1;
  logic           dinValid1;
  logic [W-1:0]   dout1;
  logic           doutValid1;
  logic           doutLast1;

  int checks = 0;
  int errors = 0;

  systolic_output_buffer #(.ACC_WIDTH(W), .length(L), .ROWS(3)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(dinValid),
    .dout(dout), .dout_valid(doutValid), .dout_last(doutLast)
  );

  systolic_output_buffer #(.ACC_WIDTH(W), .length(1), .ROWS(1)) dut1 (
    .clk(clk), .rstn(rstn), .din(din1), .din_valid(dinValid1),
    .dout(dout1), .dout_valid(doutValid1), .dout_last(doutLast1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           valid;
    logic [W*L-1:0] din;
    logic [W*L-1:0] expDout;
    logic           expValid;
    logic           expLast;
  } vec_t;

  vec_t vecs [48];
  int   nVec;

  task automatic checkVal(input string name, input logic [W*L-1:0] act, input logic [W*L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Fill every cycle with garbage on all columns and no expected output.
  task automatic clearTable(input int n);
    nVec = n;
    for (int k = 0; k < 48; k++) begin
      vecs[k].valid    = 1'b0;
      for (int j = 0; j < L; j++) begin
        vecs[k].din[W*j +: W] = 32'hBAD0_0000 | (k << 8) | j;
      end
      vecs[k].expDout  = '0;
      vecs[k].expValid = 1'b0;
      vecs[k].expLast  = 1'b0;
    end
  endtask

  // A row starting at t0: column j skewed to t0+j, aligned output at t0+L.
  task automatic placeRow(input int t0, input int base, input logic last);
    vecs[t0].valid = 1'b1;
    for (int j = 0; j < L; j++) begin
      vecs[t0+j].din[W*j +: W]   = 32'(base + j);
      vecs[t0+L].expDout[W*j +: W] = 32'(base + j);
    end
    vecs[t0+L].expValid = 1'b1;
    vecs[t0+L].expLast  = last;
  endtask

  task automatic applyStimulus(input vec_t v);
    din      = v.din;
    dinValid = v.valid;
  endtask

  task automatic checkOutput(input string tag, input int k, input vec_t v);
    checkVal($sformatf("%s[%0d].dout", tag, k), dout, v.expDout);
    checkVal($sformatf("%s[%0d].valid", tag, k), {127'b0, doutValid}, {127'b0, v.expValid});
    checkVal($sformatf("%s[%0d].last", tag, k), {127'b0, doutLast}, {127'b0, v.expLast});
  endtask

  task automatic runTable(input string tag);
    for (int k = 0; k < nVec; k++) begin
      @(negedge clk);
      checkOutput(tag, k, vecs[k]);
      applyStimulus(vecs[k]);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rstn      = 1'b0;
    dinValid  = 1'b0;
    din       = '0;
    dinValid1 = 1'b0;
    din1      = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b0;
    din       = '1;
    dinValid  = 1'b1;
    din1      = '0;
    dinValid1 = 1'b0;

    // Reset held with all-ones data and valid high: outputs stay cleared.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal($sformatf("rstHold[%0d].dout", k), dout, '0);
      checkVal($sformatf("rstHold[%0d].valid", k), {127'b0, doutValid}, '0);
      checkVal($sformatf("rstHold[%0d].last", k), {127'b0, doutLast}, '0);
    end

    // Stream all-ones, then drop rstn between edges: outputs clear without a clock.
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    checkVal("preAsync.dout", dout, '1);
    checkVal("preAsync.valid", {127'b0, doutValid}, 128'd1);
    checkVal("preAsync.last", {127'b0, doutLast}, '0);
    #2 rstn = 1'b0;
    #1;
    checkVal("async.dout", dout, '0);
    checkVal("async.valid", {127'b0, doutValid}, '0);
    checkVal("async.last", {127'b0, doutLast}, '0);
    dinValid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    applyReset();
    clearTable(9);
    placeRow(1, 32'h100, 1'b0);
    runTable("single");

    applyReset();
    clearTable(13);
    for (int r = 0; r < 6; r++) placeRow(1 + r, 16 * r, (r == 2) || (r == 5));
    runTable("b2b");

    // Valid pattern 1,0,1,1,0,0,1 starting at cycle 1; last on the 3rd valid beat.
    applyReset();
    clearTable(14);
    placeRow(1, 32'h200, 1'b0);
    placeRow(3, 32'h210, 1'b0);
    placeRow(4, 32'h220, 1'b1);
    placeRow(7, 32'h230, 1'b0);
    runTable("gapped");

    // Two rows out, two more in flight, then reset; none of them may reappear.
    applyReset();
    clearTable(7);
    for (int r = 0; r < 4; r++) placeRow(1 + r, 32'h300 + 16 * r, 1'b0);
    runTable("midPre");
    applyReset();
    clearTable(11);
    placeRow(1, 32'h400, 1'b0);
    placeRow(2, 32'h410, 1'b0);
    placeRow(3, 32'h420, 1'b1);
    runTable("midPost");

    // length=1, ROWS=1: one-cycle delay, last on every valid beat.
    applyReset();
    for (int k = 0; k < 10; k++) begin
      logic         prevValid;
      logic [W-1:0] expData;
      @(negedge clk);
      prevValid = (k >= 1) && (k - 1 < 8);
      expData   = prevValid ? 32'h1000 + 32'(k - 1) : '0;
      checkVal($sformatf("len1[%0d].dout", k), {96'b0, dout1}, {96'b0, expData});
      checkVal($sformatf("len1[%0d].valid", k), {127'b0, doutValid1}, {127'b0, prevValid});
      checkVal($sformatf("len1[%0d].last", k), {127'b0, doutLast1}, {127'b0, prevValid});
      dinValid1 = (k < 8);
      din1      = 32'h1000 + 32'(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_output_buffer.md
Name: systolic_output_buffer

Overview:
- Deskew stage at the bottom of the systolic array, mirroring the input-side skew buffer.
- Column j of the array emits its result for a given output row j cycles after column 0. This block delays column j by (length-j) register stages so that all columns of a row leave together as one aligned vector.
- It also carries a valid flag alongside the data and marks the last row of each output tile.
- Sits between the array's column outputs and the result writeback/accumulator logic.

Parameters:
- ACC_WIDTH, 32, width of one column result (accumulator width).
- length, 16, number of array columns; must be >= 1.
- ROWS, 16, output rows per tile, used for dout_last framing; must be >= 1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- din  input  ACC_WIDTH*length  skewed column results; column j is din[ACC_WIDTH*j +: ACC_WIDTH].
- din_valid  input  1  qualifies column 0 of din in this cycle. Columns j>0 of the same row are taken implicitly j cycles later.
- dout  output  ACC_WIDTH*length  aligned row; column j is dout[ACC_WIDTH*j +: ACC_WIDTH].
- dout_valid  output  1  dout holds a complete aligned row.
- dout_last  output  1  the current valid row is row ROWS-1 of the tile.

Behaviour:
- Reset (async, rstn=0): all delay registers, the valid pipeline, the row counter, dout, dout_valid and dout_last go to 0 immediately. Any in-flight rows are discarded.
- Data path:
  - Column j passes through exactly (length-j) registers: column 0 through length stages, column length-1 through 1 stage. All outputs are registered; there is no combinational din->dout path.
  - Row alignment: if din_valid=1 at cycle t0, then column j sampled at cycle t0+j appears on dout at cycle t0+length.
- Valid path:
  - din_valid passes through a length-stage shift register.
  - dout_valid = din_valid delayed exactly length cycles.
- Data masking: when dout_valid=0, dout is driven to all zeros. Data in non-valid slots is never exposed.
- Throughput:
  - One row per cycle. din_valid may be high on consecutive cycles, with any pattern of gaps.
  - No backpressure: the array cannot stall, so the downstream sink must accept every dout_valid beat.
- Row counter:
  - Width clog2(ROWS), minimum 1 bit; resets to 0.
  - Increments on each cycle where dout_valid=1.
  - When it equals ROWS-1 on a valid beat, dout_last=1 on that beat and the counter wraps to 0.
  - With ROWS=1, dout_last=1 on every valid beat.
  - dout_last is 0 whenever dout_valid=0.
- Partial tile: if valid rows stop mid-tile, the counter holds its value. It only returns to 0 on wrap or reset.
- Boundary case length=1: a single column with 1 stage, so latency is 1 cycle.
- Overlap: a new row's column 0 may enter while earlier rows' higher columns are still in flight. Every row's columns stay in separate pipeline stages, so there is no interference.
- Reset mid-operation: on rstn release, the first dout_valid occurs exactly length cycles after the first post-reset din_valid. The row counter restarts at 0.

Test Plan:
- Reset check (length=4, ACC_WIDTH=32, ROWS=3): hold rstn=0 with din=all ones and din_valid=1 -> dout=0, dout_valid=0, dout_last=0. Asserting rstn=0 mid-stream clears the outputs without waiting for a clock edge.
- Single row, same parameters:
  - Stimulus: din_valid=1 at t0; drive column j = 0x100+j at t0+j, and garbage on the other columns and cycles.
  - Required: at t0+4, dout = {0x103,0x102,0x101,0x100} with dout_valid=1 and dout_last=0.
  - All other cycles: dout=0 and dout_valid=0.
- Back-to-back rows:
  - Stimulus: din_valid high for 6 consecutive cycles; row r column j = 16*r+j, skewed per column.
  - Required: 6 consecutive aligned valid rows starting t0+4, each correct.
  - dout_last=1 on rows 2 and 5 only.
- Gapped stream: valid pattern 1,0,1,1,0,0,1 -> dout_valid shows the same pattern delayed 4 cycles. dout_last falls on the 3rd valid beat, and the counter holds through the gaps.
- Mid-tile reset: after 2 valid rows out, pulse rstn, then send 3 rows -> dout_last on the 3rd post-reset row. No pre-reset row appears on the output.
- Degenerate length=1, ROWS=1: din_valid every cycle with incrementing data -> dout equals din delayed 1 cycle, and dout_last=dout_valid=1 on every beat.
